crc: RTL and testbench
======================

# crc

Registered CRC-16 accumulator that folds one 32-bit data word per enabled clock cycle into a running checksum. Used in the switch datapath to compute frame/descriptor check values on 32-bit bus words. The checksum runs continuously from reset; it has no clear input, so the only way to restart it is reset.

## Interface
- No parameters. Polynomial, width and initial value are fixed (see Operation).
- iClk  input  1  system clock; all state updates on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset; one clock; asserting it clears the CRC register immediately.
- iData  input  32  data word to fold into the CRC; sampled only when iCrcEn=1.
- iCrcEn  input  1  enable; 1 = fold iData into the CRC on this rising edge, 0 = hold.
- oCrc  output  16  current CRC register value (direct register output, no combinational path from inputs).

## Operation
- Algorithm: CRC-16/XMODEM.
  - Polynomial 0x1021 (x^16+x^12+x^5+1).
  - Initial value 0x0000.
  - Non-reflected input and output, MSB-first, no final XOR.
- Word fold: next = F(crc, iData), equivalent to 32 serial steps taking data bits in order iData[31] down to iData[0]. Each step:
  - fb = crc[15] ^ d
  - crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000)
- Byte-order equivalence: folding a word equals running byte-wise XMODEM over iData[31:24], [23:16], [15:8], [7:0], in that order.
- Implement F as a combinational function (unrolled loop or XOR matrix). One full 32-bit fold completes per clock; no multi-cycle iteration.
- iCrcEn=1: crc_reg <= F(crc_reg, iData).
- iCrcEn=0: crc_reg holds; iData is ignored (X on iData must not propagate).
- oCrc = crc_reg.
- Consecutive enabled cycles chain: each word is folded onto the result of the previous one. Disabled cycles between enabled words do not affect the result.

## Timing
- Reset:
  - iRst_n=0 forces crc_reg, and therefore oCrc, to 0x0000 asynchronously.
  - This holds regardless of iCrcEn or iData.
  - Reset removal is synchronous to iClk; the first fold happens on the first rising edge with iRst_n=1 and iCrcEn=1.
- Latency: one cycle.
  - With iCrcEn=1 and word W present at rising edge N, oCrc shows F(prev, W) after edge N.
  - That value is stable for the whole of cycle N+1.
- Throughput: one 32-bit word per cycle, sustained, with no bubbles required.
- Reset mid-stream: the accumulated value is lost and oCrc=0x0000. Words enabled after reset release start a fresh CRC.
- Enable asserted during reset: ignored; reset dominates.
- Combinational F depth is about 32 XOR levels before optimisation. It must meet the switch core clock in a single cycle; a flattened XOR matrix is expected.

## Test plan
- Reset: hold iRst_n=0 for 10 cycles with random iData and iCrcEn -> oCrc=0x0000 throughout. Release reset with iCrcEn=0 -> oCrc stays 0x0000.
- Single word, init 0:
  - iData=0x00000001, iCrcEn=1 for one cycle -> oCrc=0x1021 the next cycle.
  - After reset, iData=0x00000080 -> oCrc=0x9188.
  - After reset, iData=0x00000000 -> oCrc=0x0000.
- Hold: after any fold, drive iCrcEn=0 for 20 cycles while toggling iData randomly, including X -> oCrc unchanged and never X.
- Latency: single enabled word at edge N -> oCrc changes only after edge N, not before, and holds at that value through cycle N+1.
- Random chain: 16 cycles with random iCrcEn and random iData, then iCrcEn=0 -> oCrc matches, every cycle, a bit-serial reference model (32 MSB-first steps per enabled word).
- Mid-stream reset: fold 3 random words, pulse iRst_n low between clock edges -> oCrc=0x0000 immediately. Then fold 0x00000001 -> oCrc=0x1021.

Source files
------------

// File: rtl/crc_if.sv
// -----------------------------------------------------------------------------
// crc_if -- data/enable/result bundle for the CRC-16 accumulator.
//   iData  [31:0]  word to fold (master -> slave)
//   iCrcEn         fold enable  (master -> slave)
//   oCrc   [15:0]  running CRC  (slave -> master)
// -----------------------------------------------------------------------------
interface crc_if;
    logic [31:0] iData;
    logic        iCrcEn;
    logic [15:0] oCrc;

    modport master (output iData, output iCrcEn, input  oCrc);
    modport slave  (input  iData, input  iCrcEn, output oCrc);
endinterface

// File: rtl/crc.sv
// -----------------------------------------------------------------------------
// crc -- registered CRC-16/XMODEM accumulator (poly 0x1021, init 0x0000,
// MSB-first, no reflection, no final XOR). Folds one 32-bit word per enabled
// clock. There is no clear input; only reset restarts the checksum.
//   iClk          system clock, rising edge
//   iRst_n        asynchronous active-low reset, clears the CRC to 0x0000
//   bus.iData     word to fold, sampled only when bus.iCrcEn = 1
//   bus.iCrcEn    1 = fold on this edge, 0 = hold
//   bus.oCrc      CRC register (direct register output)
// -----------------------------------------------------------------------------
module crc (
    input  logic  iClk,
    input  logic  iRst_n,
    crc_if.slave  bus
);

    localparam logic [15:0] POLY = 16'h1021;

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // With MSB-first shifting, the current CRC is equivalent to XORing it into
    // the first 16 message bits and starting from zero. The fold is then the
    // remainder of (msg * x^16) mod P, computed as an unrolled long division;
    // synthesis flattens it into a pure XOR matrix.
    function automatic logic [15:0] fold(input logic [15:0] c, input logic [31:0] d);
        logic [47:0] r;
        r = {d ^ {c, 16'h0000}, 16'h0000};
        for (int i = 47; i >= 16; i--) begin
            if (r[i])
                r[i -: 17] = r[i -: 17] ^ {1'b1, POLY};
        end
        return r[15:0];
    endfunction

    // The mux selects crc_q when disabled, so iData never reaches the register.
    always_comb begin
        crc_d = crc_q;
        if (bus.iCrcEn)
            crc_d = fold(crc_q, bus.iData);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            crc_q <= 16'h0000;
        else
            crc_q <= crc_d;
    end

    assign bus.oCrc = crc_q;

endmodule

// File: tb/tb_crc.sv
// -----------------------------------------------------------------------------
// tb_crc -- directed self-checking bench for crc. Hand-computed vectors for
// single words and chains, plus a bit-serial reference for random chains.
// -----------------------------------------------------------------------------
module tb_crc;

    logic iClk;
    logic iRst_n;
    crc_if bus ();

    crc dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %04h, expected %04h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-16/XMODEM, data bits 31 down to 0.
    function automatic logic [15:0] ref_fold(input logic [15:0] c, input logic [31:0] d);
        logic fb;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Present a word for one edge, then disable; result visible 1ns after the edge.
    task automatic fold_word(input logic [31:0] w);
        bus.iData  = w;
        bus.iCrcEn = 1'b1;
        @(posedge iClk); #1;
        bus.iCrcEn = 1'b0;
    endtask

    // Pulse reset between edges and release before the next edge.
    task automatic pulse_reset;
        @(posedge iClk); #2;
        iRst_n = 1'b0;
        #1;
        chk("rst_async", bus.oCrc, 16'h0000);
        #1;
        iRst_n = 1'b1;
    endtask

    logic [15:0] model;
    logic [15:0] held;

    typedef struct {
        logic [31:0] w;
        logic [15:0] exp;
        string       tag;
    } vec_t;

    initial begin
        vec_t vecs[6];
        n_chk      = 0;
        n_err      = 0;
        iRst_n     = 1'b0;
        bus.iData  = 32'h0;
        bus.iCrcEn = 1'b0;
        #1;
        chk("rst_t0", bus.oCrc, 16'h0000);

        // Reset dominates random enable/data.
        for (int i = 0; i < 10; i++) begin
            bus.iData  = $urandom;
            bus.iCrcEn = 1'($urandom_range(0, 1));
            @(posedge iClk); #1;
            chk("rst_hold", bus.oCrc, 16'h0000);
        end
        bus.iCrcEn = 1'b0;
        iRst_n     = 1'b1;
        @(posedge iClk); #1;
        chk("rst_release", bus.oCrc, 16'h0000);

        // Single words from a fresh CRC (x^k mod P values and linear combos).
        vecs[0] = '{32'h0000_0001, 16'h1021, "w_0001"};
        vecs[1] = '{32'h0000_0080, 16'h9188, "w_0080"};
        vecs[2] = '{32'h0000_0000, 16'h0000, "w_0000"};
        vecs[3] = '{32'h0000_0003, 16'h3063, "w_0003"};
        vecs[4] = '{32'h0000_8000, 16'h1B98, "w_8000"};
        vecs[5] = '{32'h0000_0081, 16'h81A9, "w_0081"};
        foreach (vecs[i]) begin
            pulse_reset();
            fold_word(vecs[i].w);
            chk(vecs[i].tag, bus.oCrc, vecs[i].exp);
        end

        // Chain: crc 0x1021, then a word whose upper half cancels it.
        pulse_reset();
        fold_word(32'h0000_0001);
        fold_word(32'h1021_0000);
        chk("chain_cancel", bus.oCrc, 16'h0000);
        fold_word(32'h0000_0001);
        fold_word(32'h1021_0001);
        chk("chain_keep", bus.oCrc, 16'h1021);
        // Back-to-back enabled cycles, no bubble.
        pulse_reset();
        bus.iData  = 32'h0000_0001;
        bus.iCrcEn = 1'b1;
        @(posedge iClk); #1;
        bus.iData  = 32'h1021_0080;
        @(posedge iClk); #1;
        bus.iCrcEn = 1'b0;
        chk("b2b", bus.oCrc, 16'h9188);

        // Hold: disabled with random and unknown data.
        held = bus.oCrc;
        for (int i = 0; i < 20; i++) begin
            bus.iData = (i % 4 == 0) ? 32'hxxxx_xxxx : 32'($urandom);
            @(posedge iClk); #1;
            chk("hold_val", bus.oCrc, held);
            chk("hold_nx", {15'h0, $isunknown(bus.oCrc)}, 16'h0000);
        end

        // Latency: value changes only after the enabled edge, stable next cycle.
        pulse_reset();
        @(negedge iClk);
        bus.iData  = 32'h0000_0080;
        bus.iCrcEn = 1'b1;
        #1;
        chk("lat_before", bus.oCrc, 16'h0000);
        @(posedge iClk); #1;
        bus.iCrcEn = 1'b0;
        bus.iData  = 32'hFFFF_FFFF;
        chk("lat_after", bus.oCrc, 16'h9188);
        @(negedge iClk);
        chk("lat_mid", bus.oCrc, 16'h9188);
        @(posedge iClk); #1;
        chk("lat_hold", bus.oCrc, 16'h9188);

        // Random chain against the bit-serial reference.
        pulse_reset();
        model = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            bus.iData  = $urandom;
            bus.iCrcEn = 1'($urandom_range(0, 1));
            if (bus.iCrcEn)
                model = ref_fold(model, bus.iData);
            @(posedge iClk); #1;
            chk("rand_chain", bus.oCrc, model);
        end
        bus.iCrcEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.iData = $urandom;
            @(posedge iClk); #1;
            chk("rand_idle", bus.oCrc, model);
        end

        // Mid-stream reset discards the accumulated value.
        pulse_reset();
        model = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            bus.iData = $urandom;
            model     = ref_fold(model, bus.iData);
            fold_word(bus.iData);
        end
        chk("mid_pre", bus.oCrc, model);
        pulse_reset();
        fold_word(32'h0000_0001);
        chk("mid_post", bus.oCrc, 16'h1021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
